apb_master_nslv: RTL and testbench

- Parametrised APB master bridge, successor to the fixed two-slave master.
- Accepts the existing testbench command interface: `transfer`, `READ_WRITE`, separate read/write addresses, write data, read data out.
- Drives a generic APB bus to NSLV slaves and decodes the slave from the upper address bits.
- Adds `pready` wait-state handling, `pslverr`/decode/timeout error reporting, and back-to-back transfers.

---
 rtl/apb_master_nslv.sv | 212 +++++++++++++++++++++
 tb/tb_apb_master_nslv.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_nslv.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_nslv
// Brief    : APB master bridge to NSLV slaves with wait states, error
//            reporting, timeout abort and back-to-back commands.
// Revision : 1.0
// ============================================================================
module apb_master_nslv #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NSLV    = 4,
    parameter int SELW    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               transfer,
    input  logic               READ_WRITE,
    input  logic [AW-1:0]      apb_read_paddr,
    input  logic [AW-1:0]      apb_write_paddr,
    input  logic [DW-1:0]      apb_write_data,
    output logic [DW-1:0]      apb_read_data_out,
    output logic               xfer_done,
    output logic               xfer_err,
    output logic               busy,
    output logic [NSLV-1:0]    psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [NSLV*DW-1:0] prdata,
    input  logic [NSLV-1:0]    pready,
    input  logic [NSLV-1:0]    pslverr
);

    localparam int              c_CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              c_TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [c_CW-1:0] c_TMAX  = c_TLIM[c_CW-1:0];
    localparam bit              c_TO_EN = (TIMEOUT != 0);
    localparam logic [SELW:0]   c_NSLV  = NSLV[SELW:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [NSLV-1:0]   r_psel, w_psel_nx;
    logic              r_penable, w_penable_nx;
    logic              r_pwrite, w_pwrite_nx;
    logic [AW-1:0]     r_paddr, w_paddr_nx;
    logic [DW-1:0]     r_pwdata, w_pwdata_nx;
    logic [DW-1:0]     r_rdata, w_rdata_nx;
    logic              r_done, w_done_nx;
    logic              r_err, w_err_nx;
    logic              r_busy, w_busy_nx;
    logic [c_CW-1:0]   r_cnt, w_cnt_nx;
    logic [SELW-1:0]   r_idx, w_idx_nx;
    logic              r_dec_pend, w_pend_nx;

    logic [AW-1:0]     w_cmd_addr;
    logic [SELW-1:0]   w_cmd_idx;
    logic              w_cmd_ok;
    logic [NSLV-1:0]   w_cmd_onehot;
    logic              w_sel_ready, w_sel_err;
    logic [DW-1:0]     w_sel_rdata;
    logic              w_accept, w_end;

    assign w_cmd_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    assign w_cmd_idx  = w_cmd_addr[AW-1 -: SELW];
    assign w_cmd_ok   = ({1'b0, w_cmd_idx} < c_NSLV);

    // Only the latched slave's handshake is looked at; others may be X.
    always_comb begin
        w_sel_ready  = 1'b0;
        w_sel_err    = 1'b0;
        w_sel_rdata  = '0;
        w_cmd_onehot = '0;
        for (int i = 0; i < NSLV; i++) begin
            w_cmd_onehot[i] = (w_cmd_idx == i[SELW-1:0]);
            if (r_idx == i[SELW-1:0]) begin
                w_sel_ready = pready[i];
                w_sel_err   = pslverr[i];
                w_sel_rdata = prdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_psel_nx    = r_psel;
        w_penable_nx = r_penable;
        w_pwrite_nx  = r_pwrite;
        w_paddr_nx   = r_paddr;
        w_pwdata_nx  = r_pwdata;
        w_rdata_nx   = r_rdata;
        w_done_nx    = 1'b0;
        w_err_nx     = 1'b0;
        w_cnt_nx     = r_cnt;
        w_idx_nx     = r_idx;
        w_pend_nx    = r_dec_pend;
        w_accept     = 1'b0;
        w_end        = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A decode error chained behind a completion is reported here.
                if (r_dec_pend) begin
                    w_done_nx = 1'b1;
                    w_err_nx  = 1'b1;
                    w_pend_nx = 1'b0;
                end else begin
                    w_accept = transfer;
                end
            end
            S_SETUP: begin
                w_penable_nx = 1'b1;
                w_state_nx   = S_ACCESS;
                w_cnt_nx     = '0;
            end
            S_ACCESS: begin
                if (w_sel_ready) begin
                    w_end     = 1'b1;
                    w_done_nx = 1'b1;
                    w_err_nx  = w_sel_err;
                    if (!r_pwrite && !w_sel_err) begin
                        w_rdata_nx = w_sel_rdata;
                    end
                end else if (c_TO_EN && (r_cnt == c_TMAX)) begin
                    w_end     = 1'b1;
                    w_done_nx = 1'b1;
                    w_err_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + c_CW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_end) begin
            w_state_nx   = S_IDLE;
            w_psel_nx    = '0;
            w_penable_nx = 1'b0;
            w_accept     = transfer;
        end

        if (w_accept) begin
            if (w_cmd_ok) begin
                w_state_nx  = S_SETUP;
                w_psel_nx   = w_cmd_onehot;
                w_pwrite_nx = ~READ_WRITE;
                w_paddr_nx  = w_cmd_addr;
                w_idx_nx    = w_cmd_idx;
                if (!READ_WRITE) begin
                    w_pwdata_nx = apb_write_data;
                end
            end else if (w_end) begin
                w_pend_nx = 1'b1;
            end else begin
                w_done_nx = 1'b1;
                w_err_nx  = 1'b1;
            end
        end

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state    <= S_IDLE;
            r_psel     <= '0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_dec_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_psel     <= w_psel_nx;
            r_penable  <= w_penable_nx;
            r_pwrite   <= w_pwrite_nx;
            r_paddr    <= w_paddr_nx;
            r_pwdata   <= w_pwdata_nx;
            r_rdata    <= w_rdata_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
            r_busy     <= w_busy_nx;
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_dec_pend <= w_pend_nx;
        end
    end

    assign psel              = r_psel;
    assign penable           = r_penable;
    assign pwrite            = r_pwrite;
    assign paddr             = r_paddr;
    assign pwdata            = r_pwdata;
    assign apb_read_data_out = r_rdata;
    assign xfer_done         = r_done;
    assign xfer_err          = r_err;
    assign busy              = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_nslv.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_nslv
// Brief    : Self-checking bench for apb_master_nslv (NSLV=4 and NSLV=3).
// Revision : 1.0
// ============================================================================
module tb_apb_master_nslv;

    logic         pclk = 1'b0;
    logic         presetn;
    logic         transfer, transfer3, READ_WRITE;
    logic [31:0]  apb_read_paddr, apb_write_paddr, apb_write_data;
    logic [31:0]  rdata, rdata3, paddr, paddr3, pwdata, pwdata3;
    logic         done, err, busy, penable, pwrite;
    logic         done3, err3, busy3, penable3, pwrite3;
    logic [3:0]   psel, pready, pslverr;
    logic [2:0]   psel3, pready3, pslverr3;
    logic [127:0] prdata;
    logic [95:0]  prdata3;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: what the bus should look like for the latched command
    logic [31:0] m_paddr, m_pwdata, m_rdata;
    logic        m_pwrite;
    logic [3:0]  m_psel;
    int          m_idx;
    bit          p_rd;
    logic [31:0] p_addr, p_wd;

    always #5 pclk = ~pclk;

    apb_master_nslv #(.AW(32), .DW(32), .NSLV(4), .SELW(2), .TIMEOUT(16)) u_dut (
        .pclk(pclk), .presetn(presetn), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_read_paddr(apb_read_paddr), .apb_write_paddr(apb_write_paddr),
        .apb_write_data(apb_write_data), .apb_read_data_out(rdata),
        .xfer_done(done), .xfer_err(err), .busy(busy), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    apb_master_nslv #(.AW(32), .DW(32), .NSLV(3), .SELW(2), .TIMEOUT(16)) u_dut3 (
        .pclk(pclk), .presetn(presetn), .transfer(transfer3), .READ_WRITE(READ_WRITE),
        .apb_read_paddr(apb_read_paddr), .apb_write_paddr(apb_write_paddr),
        .apb_write_data(apb_write_data), .apb_read_data_out(rdata3),
        .xfer_done(done3), .xfer_err(err3), .busy(busy3), .psel(psel3), .penable(penable3),
        .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3),
        .pready(pready3), .pslverr(pslverr3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input bit rd, input logic [31:0] addr, input logic [31:0] wd);
        transfer   = 1'b1;
        READ_WRITE = rd;
        if (rd) begin
            apb_read_paddr  = addr;
            apb_write_paddr = $urandom;
        end else begin
            apb_write_paddr = addr;
            apb_read_paddr  = $urandom;
        end
        apb_write_data = wd;
        p_rd = rd; p_addr = addr; p_wd = wd;
    endtask

    task automatic accept_model();
        m_idx    = int'(p_addr[31:30]);
        m_psel   = 4'b0001 << m_idx;
        m_pwrite = !p_rd;
        m_paddr  = p_addr;
        if (!p_rd) m_pwdata = p_wd;
    endtask

    task automatic idle_inputs();
        transfer        = 1'b0;
        READ_WRITE      = 1'($urandom);
        apb_read_paddr  = $urandom;
        apb_write_paddr = $urandom;
        apb_write_data  = $urandom;
    endtask

    task automatic check_bus(input string tag, input bit en);
        chk({tag, "_psel"}, psel, m_psel);
        chk({tag, "_penable"}, penable, en);
        chk({tag, "_pwrite"}, pwrite, m_pwrite);
        chk({tag, "_paddr"}, paddr, m_paddr);
        chk({tag, "_pwdata"}, pwdata, m_pwdata);
        chk({tag, "_busy"}, busy, 1'b1);
    endtask

    // ACCESS phase: selected slave waits 'waits' cycles; abort expected on the
    // 16th ACCESS cycle without ready.
    task automatic access(input string tag, input int waits, input bit slverr,
                          input logic [31:0] rdat, input bit chained);
        for (int k = 0; k < 40; k++) begin
            bit ok, fin;
            ok  = (k == waits);
            fin = ok || (k == 15);
            pready  = 4'($urandom);
            pready[m_idx] = ok;
            pslverr = 4'($urandom);
            pslverr[m_idx] = slverr;
            prdata  = {$urandom, $urandom, $urandom, $urandom};
            prdata[m_idx*32 +: 32] = ok ? rdat : $urandom;
            tick();
            if (!fin) begin
                chk({tag, "_wait_done"}, done, 1'b0);
                chk({tag, "_wait_rdata"}, rdata, m_rdata);
                check_bus({tag, "_wait"}, 1'b1);
            end else begin
                chk({tag, "_done"}, done, 1'b1);
                chk({tag, "_err"}, err, ok ? slverr : 1'b1);
                if (ok && !m_pwrite && !slverr) m_rdata = rdat;
                chk({tag, "_rdata"}, rdata, m_rdata);
                chk({tag, "_penable_end"}, penable, 1'b0);
                if (chained) begin
                    accept_model();
                    check_bus({tag, "_b2b_setup"}, 1'b0);
                end else begin
                    chk({tag, "_psel_end"}, psel, 4'b0);
                    chk({tag, "_busy_end"}, busy, 1'b0);
                end
                break;
            end
        end
        pready  = 4'b0;
        pslverr = 4'b0;
    endtask

    task automatic single(input string tag, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input bit slverr,
                          input logic [31:0] rdat);
        issue(rd, addr, wd);
        tick();
        accept_model();
        check_bus({tag, "_setup"}, 1'b0);
        chk({tag, "_setup_done"}, done, 1'b0);
        idle_inputs();
        tick();
        check_bus({tag, "_access"}, 1'b1);
        access(tag, waits, slverr, rdat, 1'b0);
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [31:0] r3;
        presetn = 1'b0;
        transfer = 1'b0; transfer3 = 1'b0; READ_WRITE = 1'b0;
        apb_read_paddr = '0; apb_write_paddr = '0; apb_write_data = '0;
        pready = '0; pslverr = '0; prdata = '0;
        pready3 = '0; pslverr3 = '0; prdata3 = '0;
        m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_pwrite = 1'b0; m_psel = '0; m_idx = 0;
        #2;
        chk("rst_psel", psel, 4'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_pwrite", pwrite, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick(); tick();
        presetn = 1'b1;
        tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_psel", psel, 4'b0);

        // Zero-wait write to slave 2
        single("wr_s2", 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        // Read from slave 1 with three wait states
        single("rd_s1", 1'b1, 32'h4000_0004, 32'h0, 3, 1'b0, 32'h1234_5678);

        // Back-to-back reads: slave 0 then slave 3
        issue(1'b1, {2'b00, 30'($urandom)}, $urandom);
        tick();
        accept_model();
        check_bus("b2b_a_setup", 1'b0);
        issue(1'b1, {2'b11, 30'($urandom)}, $urandom);
        tick();
        check_bus("b2b_a_access", 1'b1);
        access("b2b_a", 0, 1'b0, $urandom, 1'b1);
        idle_inputs();
        tick();
        check_bus("b2b_b_access", 1'b1);
        chk("b2b_b_nodone", done, 1'b0);
        access("b2b_b", 0, 1'b0, $urandom, 1'b0);

        // Slave error on write to slave 0; read data must not move
        single("slverr", 1'b0, {2'b00, 30'($urandom)}, $urandom, 1, 1'b1, 32'h0);
        // Timeout on slave 1 (never ready)
        single("tmo", 1'b1, {2'b01, 30'($urandom)}, 32'h0, 1000, 1'b0, 32'h0);

        for (int n = 0; n < 6; n++) begin
            single("rnd", 1'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)),
                   ($urandom_range(0, 3) == 0), $urandom);
        end

        // Asynchronous reset in the middle of ACCESS, then a normal write
        issue(1'b0, {2'b10, 30'($urandom)}, $urandom);
        tick();
        accept_model();
        idle_inputs();
        tick();
        check_bus("arst_access", 1'b1);
        #2 presetn = 1'b0;
        #1;
        chk("arst_psel", psel, 4'b0);
        chk("arst_penable", penable, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rdata", rdata, 32'h0);
        m_rdata = '0; m_pwdata = '0;
        tick();
        presetn = 1'b1;
        tick();
        single("post_rst", 1'b0, {2'b11, 30'($urandom)}, $urandom, 2, 1'b0, 32'h0);

        // NSLV=3 instance: good read of slave 2, then decode errors on slave 3
        r3 = $urandom;
        READ_WRITE = 1'b1;
        apb_read_paddr = 32'h8000_0020;
        pready3 = 3'b111; pslverr3 = 3'b000;
        prdata3 = {r3, 32'($urandom), 32'($urandom)};
        transfer3 = 1'b1;
        tick();
        transfer3 = 1'b0;
        chk("n3_setup_psel", psel3, 3'b100);
        tick();
        tick();
        chk("n3_rd_done", done3, 1'b1);
        chk("n3_rd_err", err3, 1'b0);
        chk("n3_rd_data", rdata3, r3);
        tick();
        apb_read_paddr = 32'hC000_0000;
        transfer3 = 1'b1;
        tick();
        chk("dec_done", done3, 1'b1);
        chk("dec_err", err3, 1'b1);
        chk("dec_psel", psel3, 3'b000);
        chk("dec_busy", busy3, 1'b0);
        tick();
        transfer3 = 1'b0;
        chk("dec_b2b_done", done3, 1'b1);
        chk("dec_b2b_err", err3, 1'b1);
        tick();
        chk("dec_end_done", done3, 1'b0);
        chk("dec_rdata_kept", rdata3, r3);
        chk("dec_psel_kept", psel3, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
